// File: rtl/gray_input_stage.sv
// Debounced Gray-code switch input: 2-flop synchronizer, IDLE/COUNT/COMMIT debounce FSM,
// registered Gray-to-binary output with a one-cycle valid pulse per commit.
module gray_input_stage #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gray_in,
    output logic [3:0] binary_code,
    output logic       valid,
    output logic       stable,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Handshake: valid is a one-cycle pulse; binary_code is meaningful from that cycle on
    // and holds until the next pulse. There is no ready; the consumer must keep up.

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    w_gray_s;
    state_t        r_state;
    logic [3:0]    r_committed;
    logic [3:0]    r_candidate;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_binary;
    logic          r_valid;
    logic          r_stable;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= gray_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_gray_s = r_sync2;

    // stable is registered together with the state so it is high exactly while in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_committed <= 4'b0000;
            r_candidate <= 4'b0000;
            r_cnt       <= '0;
            r_binary    <= 4'b0000;
            r_valid     <= 1'b0;
            r_stable    <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_gray_s != r_committed) begin
                        r_state     <= COUNT;
                        r_candidate <= w_gray_s;
                        r_stable    <= 1'b0;
                    end
                end
                COUNT: begin
                    // A bounce back to the committed value wins over a new candidate.
                    if (w_gray_s == r_committed) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_stable <= 1'b1;
                    end else if (w_gray_s != r_candidate) begin
                        r_candidate <= w_gray_s;
                        r_cnt       <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= COMMIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    r_binary    <= g2b(r_candidate);
                    r_committed <= r_candidate;
                    r_valid     <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= IDLE;
                    r_stable    <= 1'b1;
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_stable <= 1'b1;
                end
            endcase
        end
    end

    assign binary_code = r_binary;
    assign valid       = r_valid;
    assign stable      = r_stable;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_gray_input_stage.sv
// Bench for gray_input_stage (DEBOUNCE_CYCLES=4): directed vectors, expected commits queued
// with their due cycle, and a monitor that pops and compares on every valid pulse.
module tb_gray_input_stage;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic [3:0] binary_code;
    logic       valid;
    logic       stable;
    logic [1:0] dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];

    gray_input_stage #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_in     (gray_in),
        .binary_code (binary_code),
        .valid       (valid),
        .stable      (stable),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_nib(input string name, input logic [3:0] act, input logic [3:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got valid with code %b, expected no pulse (cycle %0d)",
                         binary_code, cyc);
            end else begin
                logic [3:0] e;
                int         ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check_nib("commit_code", binary_code, e);
                compared++;
                if (cyc != ec) begin
                    mismatched++;
                    $display("FAIL commit_cycle: got cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end
    end

    // driver: called at a negedge; e0 is the next posedge, where sync1 captures g
    task automatic apply(input logic [3:0] g, input int hold, input bit push,
                         input logic [3:0] exp_bin, input bit chk_stable);
        int e0;
        gray_in = g;
        e0 = cyc + 1;
        if (push) begin
            exp_q.push_back(exp_bin);
            exp_cyc_q.push_back(e0 + 7);
        end
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            if (chk_stable && j >= 3 && j <= 6) check_bit("stable_low_pending", stable, 1'b0);
            if (chk_stable && j == 7) check_bit("stable_high_after_commit", stable, 1'b1);
        end
    endtask

    logic [3:0] sweep_gray [10];
    int         rel;

    initial begin
        sweep_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                       4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
        rst_n   = 1'b1;
        gray_in = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check_nib("reset_code", binary_code, 4'b0000);
        check_bit("reset_valid", valid, 1'b0);
        check_bit("reset_stable", stable, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle at 0000 for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_bit("idle_stable", stable, 1'b1);
            check_nib("idle_code", binary_code, 4'b0000);
        end

        // 0000 -> 0011 commits binary 0010 at E0+7
        apply(4'b0011, 12, 1'b1, 4'b0010, 1'b1);
        check_nib("hold_0010", binary_code, 4'b0010);

        // back to 0000, then a bouncing 0000/0001 that must never commit
        apply(4'b0000, 12, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) apply((i % 2 == 0) ? 4'b0001 : 4'b0000, 2, 1'b0, 4'b0000, 1'b0);
        apply(4'b0000, 12, 1'b0, 4'b0000, 1'b0);
        check_nib("bounce_code", binary_code, 4'b0000);

        // 0001 briefly, then 0011: only 0011 (binary 0010) commits
        apply(4'b0001, 2, 1'b0, 4'b0000, 1'b0);
        apply(4'b0011, 12, 1'b1, 4'b0010, 1'b0);
        check_nib("retarget_code", binary_code, 4'b0010);

        // sweep Gray codes of 0..9
        for (int i = 0; i < 10; i++) apply(sweep_gray[i], 10, 1'b1, 4'(i), 1'b0);
        apply(4'b0000, 12, 1'b1, 4'b0000, 1'b0);

        // reset two cycles into COUNT for 1101, then recommit after release
        gray_in = 4'b1101;
        repeat (5) @(negedge clk);
        check_bit("pending_stable", stable, 1'b0);
        rst_n = 1'b0;
        #1;
        check_nib("async_reset_code", binary_code, 4'b0000);
        check_bit("async_reset_valid", valid, 1'b0);
        check_bit("async_reset_stable", stable, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc + 1;
        exp_q.push_back(4'b1001);
        exp_cyc_q.push_back(rel + 7);
        repeat (12) @(negedge clk);
        check_nib("final_code", binary_code, 4'b1001);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_commits: got %0d unmatched expected commits, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
